// File: rtl/slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : slot_scheduler
// Description : Round-robin time-slot scheduler for five requesters. Issues
//               a registered one-hot grant with a done/withdraw handshake,
//               a hold-time limit and a one-cycle turnaround gap between
//               grants.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_scheduler #(
    parameter int HOLD_MAX = 8,
    parameter int HOLD_W   = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [4:0] req,
    input  logic       done,
    output logic [4:0] grant,
    output logic [2:0] slot,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0]        c_idle      = 2'd0;
    localparam logic [1:0]        c_grant     = 2'd1;
    localparam logic [1:0]        c_gap       = 2'd2;
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_MAX - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_ptr;
    logic [4:0]        r_grant;
    logic [2:0]        r_slot;
    logic              r_busy;
    logic              r_timeout;
    logic [HOLD_W-1:0] r_hold;

    logic [2:0]        w_ptr_nxt;
    logic [4:0]        w_grant_nxt;
    logic [2:0]        w_slot_nxt;
    logic              w_busy_nxt;
    logic              w_timeout_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic [2:0]        w_sel;
    logic              w_found;
    logic              w_slot_req;
    logic              w_expire;
    logic              w_release;

    // (base + off) mod 5 for base, off in 0..4
    function automatic logic [2:0] f_wrap_add(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // Pick the first active request starting at the rotation pointer; the
    // scan runs backwards so the nearest candidate is the one that sticks.
    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            if (req[f_wrap_add(r_ptr, 3'(k))]) begin
                w_sel   = f_wrap_add(r_ptr, 3'(k));
                w_found = 1'b1;
            end
        end
    end

    // The grant is one-hot on the served slot, so masking req with it tells
    // whether the current owner still requests without indexing by slot.
    assign w_slot_req = |(req & r_grant);
    assign w_expire   = (r_hold == c_hold_last);
    assign w_release  = done | ~w_slot_req | w_expire;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; unused encodings fall back to IDLE
    always_comb begin
        w_state_nxt = c_idle;
        case (r_state)
            c_idle:  w_state_nxt = (enable && w_found) ? c_grant : c_idle;
            c_grant: w_state_nxt = w_release ? c_gap : c_grant;
            c_gap:   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Next values for the registered outputs, pointer and hold counter
    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_slot_nxt    = r_slot;
        w_busy_nxt    = r_busy;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_idle: begin
                if (enable && w_found) begin
                    w_grant_nxt = 5'b00001 << w_sel;
                    w_slot_nxt  = w_sel;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            c_grant: begin
                if (w_release) begin
                    w_grant_nxt   = 5'b00000;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = (r_slot == 3'd4) ? 3'd0 : r_slot + 3'd1;
                    // Expiry only flags when neither done nor a withdrawal
                    // would have released the grant anyway.
                    w_timeout_nxt = w_expire & ~done & w_slot_req;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            c_gap: begin
                w_grant_nxt = 5'b00000;
            end
            default: begin
                w_grant_nxt = 5'b00000;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ptr     <= 3'd0;
            r_grant   <= 5'b00000;
            r_slot    <= 3'd0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_slot    <= w_slot_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign grant   = r_grant;
    assign slot    = r_slot;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_slot_scheduler
// Description : Self-checking bench for slot_scheduler: directed scenarios
//               followed by randomized traffic, compared every cycle with a
//               transaction-style reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_scheduler;

    localparam int HOLD_MAX = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [4:0] req;
    logic       done;
    logic [4:0] grant;
    logic [2:0] slot;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the resource, how long they have held it,
    // whether a turnaround gap is pending, and where the next search begins.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_slot  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;

    slot_scheduler #(.HOLD_MAX(HOLD_MAX), .HOLD_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .slot    (slot),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_slot = 0; m_gap = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            bit withdrew, expired;
            withdrew = (req[m_owner] == 1'b0);
            expired  = (m_held == HOLD_MAX - 1);
            m_to = 0;
            if (done || withdrew || expired) begin
                m_to    = !done && !withdrew && expired;
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            m_to  = 0;
        end else begin
            m_to = 0;
            if (enable && req != 5'b0) begin
                for (int k = 0; k < 5; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 5]) begin
                        m_owner = (m_ptr + k) % 5;
                    end
                end
                m_slot = m_owner;
                m_held = 0;
            end
        end
    endtask

    task automatic compare();
        logic [4:0] exp_grant;
        logic [7:0] onehot_ok;
        exp_grant = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
        check("grant",   {3'b0, grant},    {3'b0, exp_grant});
        check("slot",    {5'b0, slot},     8'(m_slot));
        check("busy",    {7'b0, busy},     {7'b0, (m_owner >= 0)});
        check("timeout", {7'b0, timeout},  {7'b0, m_to});
        onehot_ok = ($countones(grant) <= 1) ? 8'd1 : 8'd0;
        check("grant_onehot", onehot_ok, 8'd1);
    endtask

    // One clock: inputs are already stable, model follows the edge, outputs
    // are sampled shortly after it.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; req = 5'b0; done = 1'b0;
        #2;
        step(); step();
        reset_n = 1'b1;
        step();

        // Single requester, done release, then search resumes at slot 3
        req = 5'b00100; enable = 1'b1;
        step();
        done = 1'b1; step();
        done = 1'b0; req = 5'b10101; step();
        step(); step();
        done = 1'b1; step();
        done = 1'b0; req = 5'b00000; step(); step();

        // All requesting, done one cycle after each grant: full rotation
        req = 5'b11111;
        for (int i = 0; i < 24; i++) begin
            done = (m_owner >= 0);
            step();
        end
        done = 1'b0; req = 5'b00000; step(); step(); step();

        // Serve slot 3 then request {0,1}: wraps to 0, then 1
        req = 5'b01000; step();
        done = 1'b1; step();
        done = 1'b0; req = 5'b00011;
        for (int i = 0; i < 8; i++) begin
            done = (m_owner >= 0);
            step();
        end
        done = 1'b0; req = 5'b00000; step(); step(); step();

        // Hold expiry: requester 1 never finishes
        req = 5'b00010;
        for (int i = 0; i < 14; i++) step();
        req = 5'b00000; step(); step(); step();

        // done coincides with expiry: no timeout
        req = 5'b00100;
        for (int i = 0; i < 12; i++) begin
            done = (m_owner >= 0 && m_held == HOLD_MAX - 1);
            step();
        end
        done = 1'b0; req = 5'b00000; step(); step(); step();

        // enable low during a grant: finish it, then stay idle until enabled
        req = 5'b11111; step();
        enable = 1'b0; step(); step(); step();
        done = 1'b1; step();
        done = 1'b0;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b1; step(); step();
        done = 1'b1; step();
        done = 1'b0; req = 5'b00000; step(); step();

        // Reset mid-grant on slot 3, then re-grant right after reset lifts
        req = 5'b01000; step(); step(); step();
        reset_n = 1'b0; step();
        reset_n = 1'b1; step(); step();
        done = 1'b1; step();
        done = 1'b0; req = 5'b00000; step(); step();

        // Randomized traffic with mostly-stable requests
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) req = 5'($urandom);
            enable  = ($urandom_range(0, 9) != 0);
            done    = ($urandom_range(0, 4) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slot_scheduler.md
Name: slot_scheduler

Overview:
- Round-robin time-slot scheduler that shares one resource among 5 requesters (indices 0..4).
- Rotation pointer is a modulo-5 counter (0,1,2,3,4,0,...), the same sequence as the team's 0..4 counter. It is extended here with request skipping, a grant/done handshake and a hold-time limit.
- Sits between the 5 requesting blocks and the shared resource. Drives a one-hot grant and the binary slot index used to steer the resource mux.

Parameters:
- HOLD_MAX, 8, maximum cycles one grant may stay asserted before forced release (legal range 2..255).
- HOLD_W, 8, width of the internal hold counter; must hold HOLD_MAX-1.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- enable  input  1  1 = new grants allowed; 0 = finish the current grant, then issue no new ones
- req  input  5  request per requester, level-sensitive, bit i = requester i
- done  input  1  granted requester finished; sampled only in GRANT
- grant  output  5  one-hot grant, registered, all-zero when none
- slot  output  3  binary index (0..4) of current or last granted requester
- busy  output  1  1 while in GRANT state
- timeout  output  1  one-cycle pulse when a grant is released by HOLD_MAX expiry

Behaviour:
- Reset: synchronous, active-low. Takes effect at any clock edge where reset_n=0, including mid-grant.
  - Reset values: state=IDLE, ptr=0, grant=5'b00000, slot=3'd0, busy=0, timeout=0, hold counter=0.
- State encoding: IDLE, GRANT, GAP. Encodings 3 and above (if binary-encoded) return to IDLE.
- IDLE:
  - If enable=1 and req!=0: select the first set req bit searching ptr, ptr+1, ..., wrapping 4->0.
  - At the next edge: grant[sel]=1, slot=sel, busy=1, hold=0, state=GRANT.
  - Otherwise stay in IDLE with outputs unchanged.
- GRANT:
  - Each cycle, evaluate the release conditions in this priority order:
    - (a) done=1;
    - (b) req[slot]=0 (requester withdrew);
    - (c) hold==HOLD_MAX-1 (expiry).
  - If any condition holds: at the next edge grant=0, busy=0, ptr=(slot==4)?0:slot+1, state=GAP. If (c) is the only cause, timeout=1 for that one cycle.
  - Otherwise hold increments and grant stays.
  - enable has no effect in GRANT.
- GAP: exactly one cycle with grant=0 (bus turnaround guard). timeout returns to 0. Then state=IDLE.
- Latency:
  - req to grant: 1 cycle from IDLE.
  - Back-to-back grants are spaced by at least 1 grant-free cycle.
  - Minimum period per grant: 3 cycles (IDLE, GRANT, GAP).
- Fairness: ptr always moves past the last served index. A requester that keeps req high waits at most 4 other grants.
- Outputs: grant is always one-hot or zero, never multi-hot. slot never leaves 0..4.
- Simultaneous events:
  - done=1 and expiry in the same cycle: release by done, timeout=0.
  - req bits that rise during GRANT or GAP are considered only in the next IDLE.

Test Plan:
- Reset then req=5'b00100, enable=1 -> grant=5'b00100 one cycle later, slot=2, busy=1. Pulse done -> grant=0 next cycle, and next search starts at ptr=3.
- req=5'b11111 held, done pulsed one cycle after each grant -> grants in order slot 0,1,2,3,4,0, each followed by a GAP cycle with grant=0.
- Pointer wrap/skip: ptr=4 after serving 3, req=5'b00011 -> next grant is slot 0, then slot 1.
- Hold limit with HOLD_MAX=8: req[1] held, done=0 -> grant high exactly 8 cycles, timeout=1 for one cycle with grant=0, then GAP and IDLE.
- enable=0 during GRANT -> current grant continues until done. After GAP no new grant while req=5'b11111; enable=1 -> grant resumes at ptr.
- reset_n=0 for one cycle mid-grant (slot=3) -> next edge grant=0, slot=0, busy=0, ptr=0. With req=5'b01000 still high, grant=5'b01000 follows one cycle after reset_n returns to 1.
